// File: rtl/mem_stage.sv
// MEM pipeline stage: takes EX/MEM control and data, runs loads and stores over a
// req/ack data-memory bus and stalls upstream while an access is outstanding.
// It also resolves the branch/jump select, registers MEM/WB for write-back, and
// flags misaligned accesses and bus timeouts in sticky error bits.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              startin_n,
    input  logic              jump,
    input  logic              branch,
    input  logic              memread,
    input  logic              memtoreg,
    input  logic              memwrite,
    input  logic              regwrite,
    input  logic              zero,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] read2,
    input  logic [REG_W-1:0]  regDstMux,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              pcsrc,
    output logic              jump_out,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [DATA_W-1:0] wb_readData,
    output logic [DATA_W-1:0] wb_aluResult,
    output logic [REG_W-1:0]  wb_regDst,
    output logic              err_misalign,
    output logic              err_timeout
);

    // The counter only has to reach TIMEOUT-1, the last WAIT cycle before abort.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic memop;
    logic aligned;
    logic in_idle;
    logic in_wait;
    logic start_access;
    logic acked;
    logic abort;

    assign memop        = memread | memwrite;
    assign aligned      = (aluResult[1:0] == 2'b00);
    assign in_idle      = (state == S_IDLE);
    assign in_wait      = (state == S_WAIT);
    assign start_access = in_idle && memop && aligned;
    assign acked        = in_wait && dmem_ack;
    assign abort        = in_wait && !dmem_ack && (cnt == CNT_MAX);

    assign stall    = start_access || (in_wait && !dmem_ack && !abort);
    assign pcsrc    = branch & zero;
    assign jump_out = jump;

    // Access FSM, bus request registers, MEM/WB register and sticky error flags.
    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_readData  <= '0;
            wb_aluResult <= '0;
            wb_regDst    <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_access) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= memwrite;
                        dmem_addr    <= aluResult;
                        dmem_wdata   <= read2;
                        state        <= S_WAIT;
                        cnt          <= '0;
                        wb_valid     <= 1'b0;
                        wb_regwrite  <= 1'b0;
                        wb_memtoreg  <= 1'b0;
                        wb_readData  <= '0;
                        wb_aluResult <= '0;
                        wb_regDst    <= '0;
                    end else begin
                        // Plain ALU op, or a misaligned access that is dropped
                        // without touching the bus and without writing back.
                        wb_valid     <= 1'b1;
                        wb_regwrite  <= regwrite & ~memop;
                        wb_memtoreg  <= memtoreg;
                        wb_readData  <= '0;
                        wb_aluResult <= aluResult;
                        wb_regDst    <= regDstMux;
                        if (memop) begin
                            err_misalign <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        state        <= S_IDLE;
                        cnt          <= '0;
                        wb_valid     <= 1'b1;
                        wb_regwrite  <= regwrite;
                        wb_memtoreg  <= memtoreg;
                        wb_readData  <= memwrite ? '0 : dmem_rdata;
                        wb_aluResult <= aluResult;
                        wb_regDst    <= regDstMux;
                    end else if (abort) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        state        <= S_IDLE;
                        cnt          <= '0;
                        err_timeout  <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_regwrite  <= 1'b0;
                        wb_memtoreg  <= memtoreg;
                        wb_readData  <= '0;
                        wb_aluResult <= aluResult;
                        wb_regDst    <= regDstMux;
                    end else begin
                        cnt          <= cnt + CNT_W'(1);
                        wb_valid     <= 1'b0;
                        wb_regwrite  <= 1'b0;
                        wb_memtoreg  <= 1'b0;
                        wb_readData  <= '0;
                        wb_aluResult <= '0;
                        wb_regDst    <= '0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register.
- Consumes EX/MEM control and data, performs load/store through a req/ack data-memory bus, and stalls the pipeline while an access is outstanding.
- Resolves the branch/jump select and registers results into MEM/WB outputs for write-back.
- Includes address-alignment and bus-timeout checking.

Parameters:
DATA_W, 32, data and address width
REG_W, 5, destination register index width
TIMEOUT, 16, max WAIT cycles before an access is aborted (>=2)

Ports:
clk  in  1  clock, rising edge
startin_n  in  1  reset, asynchronous, active-low
jump  in  1  from EX/MEM
branch  in  1  from EX/MEM
memread  in  1  from EX/MEM
memtoreg  in  1  from EX/MEM
memwrite  in  1  from EX/MEM
regwrite  in  1  from EX/MEM
zero  in  1  from EX/MEM
aluResult  in  DATA_W  from EX/MEM; memory address or ALU result
read2  in  DATA_W  from EX/MEM; store data
regDstMux  in  REG_W  from EX/MEM
dmem_req  out  1  bus request, registered
dmem_we  out  1  1=write, 0=read; valid with req
dmem_addr  out  DATA_W  registered address
dmem_wdata  out  DATA_W  registered store data
dmem_rdata  in  DATA_W  read data, valid with ack
dmem_ack  in  1  access complete, single-cycle pulse
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
pcsrc  out  1  branch & zero, combinational
jump_out  out  1  = jump, combinational
wb_valid  out  1  MEM/WB holds a real instruction
wb_regwrite  out  1  MEM/WB control
wb_memtoreg  out  1  MEM/WB control
wb_readData  out  DATA_W  loaded word
wb_aluResult  out  DATA_W  ALU result passthrough
wb_regDst  out  REG_W  destination register
err_misalign  out  1  sticky misaligned-access flag
err_timeout  out  1  sticky bus-timeout flag

Behaviour:
- Reset (async, startin_n=0):
  - State IDLE; counter 0.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata all 0.
  - All wb_* outputs 0; both err flags 0.
  - Takes effect immediately, including mid-WAIT; req drops without waiting for edge.
- memop = memread|memwrite; aligned = aluResult[1:0]==0. If both memread and memwrite are set, the access is treated as a write.
- IDLE:
  - Non-memop: stall=0; MEM/WB loads the inputs at the edge; wb_valid=1; wb_readData=0.
  - memop && !aligned: stall=0, no request. MEM/WB loads with wb_regwrite=0, wb_valid=1. err_misalign sets at the edge.
  - memop && aligned: stall=1. At the edge: req=1, we=memwrite, addr=aluResult, wdata=read2; state->WAIT, cnt=0. MEM/WB loads a bubble (all wb_* 0).
  - dmem_ack in IDLE is ignored.
- WAIT:
  - Req/we/addr/wdata are held constant. Inputs are stable because upstream is stalled.
  - ack=1: stall=0 this cycle. At the edge: req=0, state->IDLE, MEM/WB loads the inputs plus wb_readData=dmem_rdata (0 for stores), wb_valid=1.
  - ack=0 and cnt<TIMEOUT-1: stall=1; cnt++; MEM/WB loads a bubble.
  - ack=0 and cnt==TIMEOUT-1: abort. stall=0; at the edge: req=0, state->IDLE, err_timeout sets, MEM/WB loads with wb_regwrite=0, wb_valid=1.
  - ack in the same cycle as the timeout boundary: ack wins, no error.
- stall is combinational: (IDLE && memop && aligned) || (WAIT && !ack && !abort).
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Memory access: 1 + N cycles, where N = WAIT cycles up to and including the ack. Minimum 2.
- pcsrc and jump_out are combinational from the current inputs and are not gated by state. Branches are never memops.
- Error flags are sticky until reset; errors do not stop subsequent operation.

Test Plan:
- ALU op (regwrite=1, aluResult=0x0000_0042, regDstMux=5, no memop) -> next edge: wb_valid=1, wb_regwrite=1, wb_aluResult=0x42, wb_regDst=5; stall never 1.
- Load, addr 0x100, ack 3 cycles after req with rdata 0xDEAD_BEEF -> stall high 3 cycles; req high with addr=0x100, we=0; then wb_readData=0xDEADBEEF, wb_memtoreg=1; bubbles (wb_valid=0) during the stall.
- Store, addr 0x200, read2=0x1234, ack in first WAIT cycle -> req=1, we=1, wdata=0x1234 for exactly 1 cycle; stall=1 for 1 cycle; no regwrite.
- Load addr 0x103 -> no req, stall=0, err_misalign=1 and stays 1; wb_regwrite=0. Load addr 0x104 then completes normally.
- Load with no ack, TIMEOUT=16 -> stall for 16 cycles then drops; err_timeout=1; wb_regwrite=0. Also with ack exactly on the 16th WAIT cycle -> no error, data captured.
- Reset asserted in 2nd WAIT cycle -> req and wb_* go 0 immediately; after release, a late ack is ignored and state is IDLE. Separately, branch=1, zero=1 -> pcsrc=1 the same cycle.
